// File: rtl/l2_pkg.sv
// Shared definitions for the output-layer MAC: number format, saturation
// limits and the controller state encoding.
package l2_pkg;

  localparam int DATA_W        = 16;
  localparam int FRAC_BITS     = 8;
  localparam int ACC_W_DEFAULT = 40;
  localparam int PROD_W        = 2 * DATA_W;

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN1,
    DRAIN2,
    DRAIN3,
    EMIT,
    DONE
  } l2_state_t;

endpackage

// File: rtl/q88_saturate.sv
// Converts a wide Q.16 accumulator back to Q8.8: arithmetic shift right by
// FRAC_BITS (rounds toward -inf), then clamps into the signed 16-bit range.
module q88_saturate
  import l2_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] q
);

  logic signed [ACC_W-1:0]      shifted;
  logic        [ACC_W-DATA_W:0] hi_bits;
  logic                         in_range;

  // The value fits in 16 bits when every bit from the sign bit of the 16-bit
  // result upward is a copy of the same sign.
  always_comb begin
    shifted  = acc >>> FRAC_BITS;
    hi_bits  = shifted[ACC_W-1:DATA_W-1];
    in_range = (&hi_bits) | (~|hi_bits);
    if (in_range) begin
      q = shifted[DATA_W-1:0];
    end else if (shifted[ACC_W-1]) begin
      q = SAT_MIN;
    end else begin
      q = SAT_MAX;
    end
  end

endmodule

// File: rtl/layer2_mac.sv
// Output-layer multiply-accumulate: for each output neuron, streams the
// hidden activation row and the matching weight row, accumulates the Q8.8
// dot product and emits one saturated result per neuron.
module layer2_mac
  import l2_pkg::*;
#(
  parameter int N_IN    = 16,
  parameter int N_OUT   = 10,
  parameter int ACT_ROW = 0,
  parameter int ACC_W   = ACC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic [3:0]        gs_row,
  output logic [3:0]        gs_col,
  input  logic [DATA_W-1:0] gs_rdata,
  output logic [3:0]        w2_addr,
  input  logic [DATA_W-1:0] w2_q,
  output logic              weight2_loadNextRow,
  output logic [DATA_W-1:0] m2result,
  output logic              m2_valid,
  output logic [3:0]        m2_idx,
  output logic              done
);

  localparam logic [3:0] I_LAST = 4'(N_IN - 1);
  localparam logic [3:0] J_LAST = 4'(N_OUT - 1);

  l2_state_t state_reg, state_next;
  logic [3:0] i_reg, i_next;
  logic [3:0] j_reg, j_next;
  logic       acc_clr;

  logic                     issue_d1_reg;
  logic                     prod_vld_reg;
  logic signed [PROD_W-1:0] prod_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic        [DATA_W-1:0] sat_q;

  logic [3:0]        gs_row_reg, gs_col_reg, w2_addr_reg, m2_idx_reg;
  logic              busy_reg, m2_valid_reg, load_next_reg, done_reg;
  logic [DATA_W-1:0] m2result_reg;

  // State, address counter and neuron counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
    end
  end

  // Next-state logic; counters stop at their last value instead of wrapping.
  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    acc_clr    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ISSUE;
          i_next     = '0;
          j_next     = '0;
          acc_clr    = 1'b1;
        end
      end
      ISSUE: begin
        if (i_reg == I_LAST) begin
          state_next = DRAIN1;
          i_next     = '0;
        end else begin
          i_next = i_reg + 4'd1;
        end
      end
      DRAIN1: state_next = DRAIN2;
      DRAIN2: state_next = DRAIN3;
      DRAIN3: state_next = EMIT;
      EMIT: begin
        if (j_reg < J_LAST) begin
          state_next = ISSUE;
          j_next     = j_reg + 4'd1;
          i_next     = '0;
          acc_clr    = 1'b1;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        j_next     = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  // Two-stage datapath: SRAM data arrives the cycle after its address, is
  // multiplied into prod_reg, then added into the accumulator a cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_d1_reg <= 1'b0;
      prod_vld_reg <= 1'b0;
      prod_reg     <= '0;
      acc_reg      <= '0;
    end else begin
      issue_d1_reg <= (state_reg == ISSUE);
      prod_vld_reg <= issue_d1_reg;
      if (issue_d1_reg) begin
        prod_reg <= $signed(gs_rdata) * $signed(w2_q);
      end
      if (acc_clr) begin
        acc_reg <= '0;
      end else if (prod_vld_reg) begin
        acc_reg <= acc_reg + {{(ACC_W-PROD_W){prod_reg[PROD_W-1]}}, prod_reg};
      end
    end
  end

  q88_saturate #(.ACC_W(ACC_W)) u_sat (
    .acc (acc_reg),
    .q   (sat_q)
  );

  // Outputs are registered from the next-state view so each pulse lines up
  // with the state it belongs to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gs_row_reg    <= '0;
      gs_col_reg    <= '0;
      w2_addr_reg   <= '0;
      busy_reg      <= 1'b0;
      m2_valid_reg  <= 1'b0;
      load_next_reg <= 1'b0;
      done_reg      <= 1'b0;
      m2_idx_reg    <= '0;
      m2result_reg  <= '0;
    end else begin
      gs_row_reg    <= (state_next == ISSUE) ? 4'(ACT_ROW) : 4'd0;
      gs_col_reg    <= (state_next == ISSUE) ? i_next : 4'd0;
      w2_addr_reg   <= (state_next == ISSUE) ? i_next : 4'd0;
      busy_reg      <= (state_next != IDLE);
      m2_valid_reg  <= (state_next == EMIT);
      load_next_reg <= (state_next == EMIT);
      done_reg      <= (state_next == DONE);
      if (state_next == EMIT) begin
        m2_idx_reg <= j_reg;
      end
      if (state_reg == DRAIN3) begin
        m2result_reg <= sat_q;
      end
    end
  end

  assign gs_row              = gs_row_reg;
  assign gs_col              = gs_col_reg;
  assign w2_addr             = w2_addr_reg;
  assign busy                = busy_reg;
  assign m2_valid            = m2_valid_reg;
  assign weight2_loadNextRow = load_next_reg;
  assign done                = done_reg;
  assign m2_idx              = m2_idx_reg;
  assign m2result            = m2result_reg;

endmodule

// File: tb/tb_layer2_mac.sv
// Directed bench: one single-neuron instance for arithmetic cases and one
// ten-neuron instance for the full run, restart and reset-abort cases.
module tb_layer2_mac;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic        busy_a, m2_valid_a, wl_a, done_a;
  logic [3:0]  gs_row_a, gs_col_a, w2_addr_a, m2_idx_a;
  logic [15:0] m2result_a;
  logic [15:0] gs_rdata_a = 16'h0;
  logic [15:0] w2_q_a = 16'h0;
  logic [15:0] act_a = 16'h0;
  logic [15:0] w_a = 16'h0;

  logic        busy_b, m2_valid_b, wl_b, done_b;
  logic [3:0]  gs_row_b, gs_col_b, w2_addr_b, m2_idx_b;
  logic [15:0] m2result_b;
  logic [15:0] gs_rdata_b = 16'h0;
  logic [15:0] w2_q_b = 16'h0;
  logic [7:0]  row_b = 8'd0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  layer2_mac #(.N_IN(16), .N_OUT(1), .ACT_ROW(0), .ACC_W(40)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a),
    .gs_row(gs_row_a), .gs_col(gs_col_a), .gs_rdata(gs_rdata_a),
    .w2_addr(w2_addr_a), .w2_q(w2_q_a), .weight2_loadNextRow(wl_a),
    .m2result(m2result_a), .m2_valid(m2_valid_a), .m2_idx(m2_idx_a),
    .done(done_a)
  );

  layer2_mac #(.N_IN(16), .N_OUT(10), .ACT_ROW(0), .ACC_W(40)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b),
    .gs_row(gs_row_b), .gs_col(gs_col_b), .gs_rdata(gs_rdata_b),
    .w2_addr(w2_addr_b), .w2_q(w2_q_b), .weight2_loadNextRow(wl_b),
    .m2result(m2result_b), .m2_valid(m2_valid_b), .m2_idx(m2_idx_b),
    .done(done_b)
  );

  // SRAM models with one-cycle read latency.
  always @(posedge clk) begin
    gs_rdata_a <= act_a;
    w2_q_a     <= w_a;
    gs_rdata_b <= (gs_row_b == 4'd0) ? 16'h0100 : 16'hDEAD;
    w2_q_b     <= {row_b + 8'd1, 8'h00};
    if (!reset || (start_b && !busy_b)) row_b <= 8'd0;
    else if (wl_b) row_b <= row_b + 8'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One single-neuron run on instance A with constant operands.
  task automatic run_a(input string tag, input logic [15:0] act, input logic [15:0] w,
                       input logic [15:0] exp_res);
    int emit_cyc, done_cyc;
    logic [15:0] res;
    logic [3:0] idx;
    logic lnr, busy22;
    emit_cyc = -1; done_cyc = -1; res = 16'h0; idx = 4'hF; lnr = 1'b0; busy22 = 1'b1;
    act_a = act;
    w_a = w;
    repeat (2) @(negedge clk);
    start_a = 1'b1;                 // cycle 0
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (m2_valid_a && emit_cyc < 0) begin
        emit_cyc = c; res = m2result_a; idx = m2_idx_a; lnr = wl_a;
      end
      if (done_a && done_cyc < 0) done_cyc = c;
      if (c == 22) busy22 = busy_a;
    end
    $display("[TB] %s: emit@%0d result=%h idx=%0d done@%0d", tag, emit_cyc, res, idx, done_cyc);
    chk({tag, "_result"}, 64'(res), 64'(exp_res));
    chk({tag, "_emit_cycle"}, 64'(emit_cyc), 64'd20);
    chk({tag, "_idx"}, 64'(idx), 64'd0);
    chk({tag, "_loadnext"}, 64'(lnr), 64'd1);
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'd21);
    chk({tag, "_busy_c22"}, 64'(busy22), 64'd0);
  endtask

  // Ten-neuron run on instance B; optionally re-pulses start mid-run.
  task automatic run_b(input string tag, input int restart_cyc);
    int k, done_cyc, sweep_err, ph;
    logic [3:0] expcol;
    logic [15:0] exp_res;
    k = 0; done_cyc = -1; sweep_err = 0;
    @(negedge clk);
    start_b = 1'b1;                 // cycle 0
    for (int c = 1; c <= 230; c++) begin
      @(negedge clk);
      start_b = (c == restart_cyc);
      ph = c % 20;
      expcol = (c <= 200 && ph >= 1 && ph <= 16) ? 4'(ph - 1) : 4'd0;
      if (gs_col_b !== expcol || w2_addr_b !== expcol || gs_row_b !== 4'd0) sweep_err++;
      if (m2_valid_b) begin
        exp_res = ((k + 1) * 4096 > 32767) ? 16'h7FFF : 16'((k + 1) * 4096);
        $display("[TB] %s: neuron %0d emit@%0d result=%h idx=%0d", tag, k, c, m2result_b, m2_idx_b);
        chk({tag, "_emit_cycle"}, 64'(c), 64'(20 * (k + 1)));
        chk({tag, "_idx"}, 64'(m2_idx_b), 64'(k));
        chk({tag, "_result"}, 64'(m2result_b), 64'(exp_res));
        chk({tag, "_loadnext"}, 64'(wl_b), 64'd1);
        k++;
      end
      if (done_b && done_cyc < 0) done_cyc = c;
    end
    $display("[TB] %s: %0d emits, done@%0d, sweep errors %0d", tag, k, done_cyc, sweep_err);
    chk({tag, "_emit_count"}, 64'(k), 64'd10);
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'd201);
    chk({tag, "_addr_sweep"}, 64'(sweep_err), 64'd0);
  endtask

  initial begin
    int stray;
    // Reset state.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset: a_outs=%h b_outs=%h",
             {m2result_a, m2_idx_a, gs_row_a, gs_col_a, w2_addr_a, busy_a, m2_valid_a, done_a, wl_a},
             {m2result_b, m2_idx_b, gs_row_b, gs_col_b, w2_addr_b, busy_b, m2_valid_b, done_b, wl_b});
    chk("reset_outs_a", 64'({m2result_a, m2_idx_a, gs_row_a, gs_col_a, w2_addr_a,
                             busy_a, m2_valid_a, done_a, wl_a}), 64'd0);
    chk("reset_outs_b", 64'({m2result_b, m2_idx_b, gs_row_b, gs_col_b, w2_addr_b,
                             busy_b, m2_valid_b, done_b, wl_b}), 64'd0);
    // Start coincident with reset low: reset must win.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("start_in_reset_busy", 64'(busy_b), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("start_in_reset_idle", 64'(busy_b), 64'd0);

    // Arithmetic cases on the single-neuron instance.
    run_a("unit",    16'h0100, 16'h0100, 16'h1000);
    run_a("neg",     16'h0100, 16'hFF00, 16'hF000);
    run_a("mixed",   16'h0080, 16'hFE00, 16'hF000);
    run_a("sat_pos", 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_a("sat_neg", 16'h7FFF, 16'h8000, 16'h8000);

    // Full ten-neuron run, then the same with a stray start at cycle 50.
    run_b("full", -1);
    run_b("restart", 50);

    // Reset at cycle 30 aborts the run.
    @(negedge clk);
    start_b = 1'b1;                 // cycle 0
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start_b = 1'b0;
    end
    reset = 1'b0;                   // sampled at end of cycle 30
    @(negedge clk);
    $display("[TB] abort: outs after reset=%h",
             {m2result_b, m2_idx_b, gs_row_b, gs_col_b, w2_addr_b, busy_b, m2_valid_b, done_b, wl_b});
    chk("abort_outs", 64'({m2result_b, m2_idx_b, gs_row_b, gs_col_b, w2_addr_b,
                           busy_b, m2_valid_b, done_b, wl_b}), 64'd0);
    reset = 1'b1;
    stray = 0;
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      if (m2_valid_b || done_b || busy_b || wl_b) stray++;
    end
    $display("[TB] abort: stray activity cycles=%0d", stray);
    chk("abort_quiet", 64'(stray), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
